// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory-side MAR/MDR responder: state encoding,
// default widths and the wait-state limit.
package mem_responder_pkg;

  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_ADDR_W      = 9;
  localparam int unsigned DEF_WAIT_CYCLES = 2;
  localparam int unsigned WAIT_MAX        = 15;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the control unit (master) and the memory
// responder (slave).
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic [ADDR_W-1:0] MAR_addr;
  logic [DATA_W-1:0] MDR_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] Mdatain;
  logic              mem_done;
  logic              mem_busy;
  logic              mem_err;

  modport master (
    output MAR_addr, MDR_wdata, mem_read, mem_write,
    input  Mdatain, mem_done, mem_busy, mem_err
  );

  modport slave (
    input  MAR_addr, MDR_wdata, mem_read, mem_write,
    output Mdatain, mem_done, mem_busy, mem_err
  );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous word RAM. The read register only loads on re_i so
// it holds the last read word; contents are never cleared by reset.
module mem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side end of the MAR/MDR interface: accepts one read or write, waits
// WAIT_CYCLES, performs the array access and pulses mem_done.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic            clk,
  input  logic            clr,
  mem_responder_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);
  localparam mem_state_e ACCEPT_ST = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;

  mem_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic              done_q;
  logic              busy_q;
  logic              err_q;
  logic              arr_we;
  logic              arr_re;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.mem_read ^ bus.mem_write) begin
            addr_q  <= bus.MAR_addr;
            wdata_q <= bus.MDR_wdata;
            wr_q    <= bus.mem_write;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            state_q <= ACCEPT_ST;
          end else if (bus.mem_read && bus.mem_write) begin
            err_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) state_q <= ST_ACCESS;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        ST_ACCESS: begin
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Array access happens on the ACCESS edge; the read register becomes Mdatain.
  always_comb begin
    arr_we = (state_q == ST_ACCESS) && wr_q;
    arr_re = (state_q == ST_ACCESS) && !wr_q;
  end

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk_i   (clk),
    .rst_ni  (clr),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (bus.Mdatain)
  );

  assign bus.mem_done = done_q;
  assign bus.mem_busy = busy_q;
  assign bus.mem_err  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with two wait states, one with none,
// checked against a word-array reference model.
module tb_mem_responder;

  logic clk = 1'b0;
  logic clr0 = 1'b0;
  logic clr1 = 1'b0;

  always #5 clk = ~clk;

  mem_responder_if #(.DATA_W(32), .ADDR_W(9)) b0 ();
  mem_responder_if #(.DATA_W(32), .ADDR_W(9)) b1 ();

  mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(2)) dut0 (
    .clk (clk), .clr (clr0), .bus (b0.slave)
  );
  mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(0)) dut1 (
    .clk (clk), .clr (clr1), .bus (b1.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int wc [2] = '{2, 0};

  logic [31:0] ref_mem [2][512];
  bit          ref_val [2][512];
  logic [31:0] ref_md  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int s, input logic rd, input logic wr,
                       input logic [8:0] a, input logic [31:0] d);
    if (s == 0) begin
      b0.mem_read = rd; b0.mem_write = wr; b0.MAR_addr = a; b0.MDR_wdata = d;
    end else begin
      b1.mem_read = rd; b1.mem_write = wr; b1.MAR_addr = a; b1.MDR_wdata = d;
    end
  endtask

  task automatic sample(input int s, output logic [31:0] md, output logic dn,
                        output logic bs, output logic er);
    if (s == 0) begin
      md = b0.Mdatain; dn = b0.mem_done; bs = b0.mem_busy; er = b0.mem_err;
    end else begin
      md = b1.Mdatain; dn = b1.mem_done; bs = b1.mem_busy; er = b1.mem_err;
    end
  endtask

  task automatic check_idle(input int s, input string tag);
    logic [31:0] md;
    logic dn, bs, er;
    sample(s, md, dn, bs, er);
    check($sformatf("%s%0d.busy", tag, s), {31'b0, bs}, 32'd0);
    check($sformatf("%s%0d.done", tag, s), {31'b0, dn}, 32'd0);
    check($sformatf("%s%0d.err", tag, s), {31'b0, er}, 32'd0);
    check($sformatf("%s%0d.mdat", tag, s), md, ref_md[s]);
  endtask

  // kind: 0 read, 1 write, 2 read+write together. poke: write 99 to 0x002 while busy.
  task automatic do_op(input int s, input int kind, input logic [8:0] a,
                       input logic [31:0] d, input bit poke);
    logic [31:0] md, md_done;
    logic dn, bs, er;
    int lat, busy_n, done_n;
    @(negedge clk);
    drive(s, kind != 1, kind != 0, a, d);
    @(posedge clk); #1;
    drive(s, 1'b0, 1'b0, '0, '0);
    sample(s, md, dn, bs, er);
    if (kind == 2) begin
      check($sformatf("err%0d.pulse", s), {31'b0, er}, 32'd1);
      check($sformatf("err%0d.busy", s), {31'b0, bs}, 32'd0);
      check($sformatf("err%0d.done", s), {31'b0, dn}, 32'd0);
      @(posedge clk); #1;
      check_idle(s, "err_after");
      return;
    end
    if (kind == 1) begin
      ref_mem[s][a] = d;
      ref_val[s][a] = 1'b1;
    end else begin
      ref_md[s] = ref_mem[s][a];
    end
    check($sformatf("op%0d.accept_busy", s), {31'b0, bs}, 32'd1);
    busy_n = bs ? 1 : 0;
    done_n = 0;
    lat = 0;
    md_done = 'x;
    for (int c = 1; c <= wc[s] + 5; c++) begin
      if (poke && c == 1) begin
        @(negedge clk);
        drive(s, 1'b0, 1'b1, 9'h002, 32'd99);
      end
      @(posedge clk); #1;
      if (poke && c == 1) drive(s, 1'b0, 1'b0, '0, '0);
      sample(s, md, dn, bs, er);
      if (bs) busy_n++;
      if (dn) begin
        done_n++;
        if (lat == 0) begin lat = c; md_done = md; end
      end
    end
    check($sformatf("op%0d.done_latency", s), lat, wc[s] + 1);
    check($sformatf("op%0d.done_count", s), done_n, 1);
    check($sformatf("op%0d.busy_cycles", s), busy_n, wc[s] + 2);
    check($sformatf("op%0d.mdat_at_done", s), md_done, ref_md[s]);
    check_idle(s, "op_after");
  endtask

  initial begin
    logic [8:0] ra;
    int r;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    ref_md[0] = '0;
    ref_md[1] = '0;
    for (int i = 0; i < 512; i++) begin
      ref_val[0][i] = 1'b0;
      ref_val[1][i] = 1'b0;
    end

    repeat (2) @(posedge clk);
    #1;
    check_idle(0, "reset");
    check_idle(1, "reset");
    @(negedge clk);
    clr0 = 1'b1;
    clr1 = 1'b1;

    // Two wait states: write/read, reset mid-write, illegal, busy poke, hold
    do_op(0, 1, 9'h005, 32'd15, 1'b0);
    do_op(0, 0, 9'h005, 32'd0, 1'b0);
    do_op(0, 1, 9'h010, 32'h0, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 9'h010, 32'hDEADBEEF);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    clr0 = 1'b0;
    @(posedge clk); #1;
    ref_md[0] = '0;
    check_idle(0, "midreset");
    @(negedge clk);
    clr0 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_idle(0, "midreset_later");
    do_op(0, 0, 9'h010, 32'd0, 1'b0);
    check($sformatf("midreset.read"), ref_md[0], 32'h0);
    do_op(0, 1, 9'h001, 32'd44, 1'b0);
    do_op(0, 0, 9'h001, 32'd0, 1'b0);
    do_op(0, 2, 9'h001, 32'd77, 1'b0);
    do_op(0, 1, 9'h002, 32'd30, 1'b0);
    do_op(0, 0, 9'h001, 32'd0, 1'b1);
    do_op(0, 0, 9'h002, 32'd0, 1'b0);
    do_op(0, 1, 9'h020, 32'd5, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_idle(0, "hold");

    // Zero wait states: top address and back-to-back reads
    do_op(1, 1, 9'h000, 32'd7, 1'b0);
    do_op(1, 1, 9'h1FF, 32'hFFFF_0001, 1'b0);
    do_op(1, 0, 9'h1FF, 32'd0, 1'b0);
    do_op(1, 0, 9'h000, 32'd0, 1'b0);
    do_op(1, 1, 9'h002, 32'd30, 1'b0);
    do_op(1, 0, 9'h000, 32'd0, 1'b1);
    do_op(1, 0, 9'h002, 32'd0, 1'b0);
    do_op(1, 2, 9'h003, 32'd1, 1'b0);

    // Randomized mix of reads, writes and illegal requests
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 40; n++) begin
        r  = $urandom_range(0, 9);
        ra = 9'($urandom_range(0, 511));
        if (r < 2) begin
          do_op(s, 2, ra, $urandom, 1'b0);
        end else if (r < 6) begin
          do_op(s, 1, ra, $urandom, 1'b0);
        end else begin
          for (int k = 0; k < 512 && !ref_val[s][ra]; k++) ra = ra + 9'd1;
          if (ref_val[s][ra]) do_op(s, 0, ra, 32'd0, 1'b0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
